// File: rtl/rgb_column_feeder.sv
// rgb_column_feeder: buffers three image rows per colour channel and sweeps
// 3x3 windows across them, presenting one 3-row column per cycle to a
// downstream array, together with the kernel weights captured at frame start.
module rgb_column_feeder #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_W      = 8,
  parameter int IMG_H      = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [9*DATA_WIDTH-1:0] kernel_r,
  input  logic [9*DATA_WIDTH-1:0] kernel_g,
  input  logic [9*DATA_WIDTH-1:0] kernel_b,
  input  logic                    pix_valid,
  input  logic [DATA_WIDTH-1:0]   pix_r,
  input  logic [DATA_WIDTH-1:0]   pix_g,
  input  logic [DATA_WIDTH-1:0]   pix_b,
  output logic                    pix_ready,
  output logic                    load_weight,
  output logic [9*DATA_WIDTH-1:0] weights_r,
  output logic [9*DATA_WIDTH-1:0] weights_g,
  output logic [9*DATA_WIDTH-1:0] weights_b,
  output logic [3*DATA_WIDTH-1:0] input_col_r,
  output logic [3*DATA_WIDTH-1:0] input_col_g,
  output logic [3*DATA_WIDTH-1:0] input_col_b,
  output logic                    col_valid,
  output logic                    total_window_done,
  output logic                    frame_done,
  output logic                    busy
);

  localparam int DW = DATA_WIDTH;
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H + 1);

  typedef enum logic [2:0] {IDLE, LOAD_W, FILL, SWEEP, WDONE, FINISH} state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic               r_start;
  logic [CW-1:0]      r_col;
  logic [RW-1:0]      r_rows;
  logic [1:0]         r_wslot;
  logic [CW-1:0]      r_x0;
  logic [1:0]         r_k;
  logic [9*DW-1:0]    r_weights_r;
  logic [9*DW-1:0]    r_weights_g;
  logic [9*DW-1:0]    r_weights_b;

  logic               w_accept;
  logic               w_row_end;
  logic               w_last_x0;
  logic               w_rows_full;
  logic               w_start_take;
  logic               w_col_valid;
  logic [CW-1:0]      w_cidx;
  logic [1:0]         w_slot_mid;
  logic [1:0]         w_slot_new;

  assign w_accept     = (r_state == FILL) && pix_valid;
  assign w_row_end    = w_accept && (r_col == CW'(IMG_W - 1));
  assign w_last_x0    = (r_x0 == CW'(IMG_W - 3));
  assign w_rows_full  = (r_rows == RW'(IMG_H));
  // Start is registered once before it moves the FSM; a second start while
  // the first is pending is dropped so the captured kernel stays stable.
  assign w_start_take = start && (r_state == IDLE) && !r_start;
  assign w_col_valid  = (r_state == SWEEP);
  assign w_cidx       = r_x0 + CW'(r_k);

  // After a row completes, the write slot points at the oldest of the three
  // buffered rows; the other two follow it in ring order.
  assign w_slot_mid = (r_wslot == 2'd2) ? 2'd0 : r_wslot + 2'd1;
  assign w_slot_new = (r_wslot == 2'd0) ? 2'd2 : r_wslot - 2'd1;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state decode.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:   if (r_start) w_state_next = LOAD_W;
      LOAD_W: w_state_next = FILL;
      FILL:   if (w_row_end && (r_rows >= RW'(2))) w_state_next = SWEEP;
      SWEEP:  if (r_k == 2'd2) w_state_next = WDONE;
      WDONE: begin
        if (!w_last_x0)      w_state_next = SWEEP;
        else if (w_rows_full) w_state_next = FINISH;
        else                 w_state_next = FILL;
      end
      FINISH: w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Start capture, kernel capture and raster / window counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_start     <= 1'b0;
      r_col       <= '0;
      r_rows      <= '0;
      r_wslot     <= '0;
      r_x0        <= '0;
      r_k         <= '0;
      r_weights_r <= '0;
      r_weights_g <= '0;
      r_weights_b <= '0;
    end else begin
      r_start <= w_start_take;
      if (w_start_take) begin
        r_weights_r <= kernel_r;
        r_weights_g <= kernel_g;
        r_weights_b <= kernel_b;
      end
      case (r_state)
        IDLE: begin
          if (r_start) begin
            r_col   <= '0;
            r_rows  <= '0;
            r_wslot <= '0;
            r_x0    <= '0;
            r_k     <= '0;
          end
        end
        FILL: begin
          if (w_accept) begin
            if (w_row_end) begin
              r_col   <= '0;
              r_rows  <= r_rows + RW'(1);
              r_wslot <= (r_wslot == 2'd2) ? 2'd0 : r_wslot + 2'd1;
              r_x0    <= '0;
              r_k     <= '0;
            end else begin
              r_col <= r_col + CW'(1);
            end
          end
        end
        SWEEP: r_k <= r_k + 2'd1;
        WDONE: begin
          r_k <= '0;
          if (!w_last_x0) r_x0 <= r_x0 + CW'(1);
        end
        default: ;
      endcase
    end
  end

  logic [DW-1:0]   w_pix [3];
  logic [3*DW-1:0] w_col [3];

  assign w_pix[0] = pix_r;
  assign w_pix[1] = pix_g;
  assign w_pix[2] = pix_b;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_chan
      logic [DW-1:0] r_lb [3][IMG_W];

      // Three-row line buffer for one colour channel, written in raster order.
      always_ff @(posedge clk) begin
        if (w_accept) r_lb[r_wslot][r_col] <= w_pix[gi];
      end

      assign w_col[gi] = w_col_valid ?
                         {r_lb[w_slot_new][w_cidx], r_lb[w_slot_mid][w_cidx], r_lb[r_wslot][w_cidx]} :
                         '0;
    end
  endgenerate

  assign pix_ready         = (r_state == FILL);
  assign load_weight       = (r_state == LOAD_W);
  assign col_valid         = w_col_valid;
  assign total_window_done = (r_state == WDONE);
  assign frame_done        = (r_state == FINISH);
  assign busy              = (r_state != IDLE);
  assign weights_r         = r_weights_r;
  assign weights_g         = r_weights_g;
  assign weights_b         = r_weights_b;
  assign input_col_r       = w_col[0];
  assign input_col_g       = w_col[1];
  assign input_col_b       = w_col[2];

endmodule

// File: tb/tb_rgb_column_feeder.sv
// Testbench for rgb_column_feeder on a 4x4 frame: start timing, column
// sequence with and without input stalls, start while busy, reset mid-frame.
module tb_rgb_column_feeder;

  localparam logic [71:0] KA_R = 72'h010203040506070809;
  localparam logic [71:0] KA_G = 72'h111213141516171819;
  localparam logic [71:0] KA_B = 72'h212223242526272829;
  localparam logic [71:0] KB_R = 72'hF1F2F3F4F5F6F7F8F9;
  localparam logic [71:0] KB_G = 72'hE1E2E3E4E5E6E7E8E9;
  localparam logic [71:0] KB_B = 72'hD1D2D3D4D5D6D7D8D9;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [71:0] kernel_r, kernel_g, kernel_b;
  logic        pix_valid;
  logic [7:0]  pix_r, pix_g, pix_b;
  logic        pix_ready;
  logic        load_weight;
  logic [71:0] weights_r, weights_g, weights_b;
  logic [23:0] input_col_r, input_col_g, input_col_b;
  logic        col_valid;
  logic        total_window_done;
  logic        frame_done;
  logic        busy;

  rgb_column_feeder #(.DATA_WIDTH(8), .IMG_W(4), .IMG_H(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .kernel_r(kernel_r), .kernel_g(kernel_g), .kernel_b(kernel_b),
    .pix_valid(pix_valid), .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
    .pix_ready(pix_ready), .load_weight(load_weight),
    .weights_r(weights_r), .weights_g(weights_g), .weights_b(weights_b),
    .input_col_r(input_col_r), .input_col_g(input_col_g), .input_col_b(input_col_b),
    .col_valid(col_valid), .total_window_done(total_window_done),
    .frame_done(frame_done), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          pulse;
    logic [23:0] r;
    logic [23:0] g;
    logic [23:0] b;
  } obs_t;

  typedef struct {
    bit          pulse;
    logic [23:0] r;
  } exp_t;

  obs_t obs[$];
  exp_t exp_tab[16];

  int n_checks = 0;
  int n_errors = 0;
  int n_acc = 0;
  int n_colv = 0;
  int n_pulse = 0;
  int n_fdone = 0;
  int first_col_acc = -1;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Observe columns and pulses each cycle, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (col_valid) begin
        obs.push_back('{1'b0, input_col_r, input_col_g, input_col_b});
        n_colv++;
        if (first_col_acc < 0) first_col_acc = n_acc;
        $display("col r=%h g=%h b=%h", input_col_r, input_col_g, input_col_b);
        chk("ready_low_in_sweep", {71'd0, pix_ready}, 72'd0);
      end else begin
        chk("col_zero_when_invalid", {input_col_r, input_col_g, input_col_b}, 72'd0);
      end
      if (total_window_done) begin
        obs.push_back('{1'b1, 24'd0, 24'd0, 24'd0});
        n_pulse++;
        $display("window done");
      end
      if (frame_done) begin
        n_fdone++;
        $display("frame done");
      end
    end
  end

  task automatic clear_obs();
    obs.delete();
    n_acc = 0;
    n_colv = 0;
    n_pulse = 0;
    n_fdone = 0;
    first_col_acc = -1;
  endtask

  task automatic do_start(input logic [71:0] kr, input logic [71:0] kg, input logic [71:0] kb);
    @(negedge clk);
    kernel_r = kr;
    kernel_g = kg;
    kernel_b = kb;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Stream the 4x4 frame (r = 4y+x, g = r+64, b = r+128) until frame_done,
  // or until the first window pulse when stop_at_pulse is set.
  task automatic run_pixels(input bit stall, input bit stop_at_pulse, input bit inject);
    int  i = 0;
    bit  v, rdy, hit, injected;
    hit = 1'b0;
    injected = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (frame_done || (stop_at_pulse && total_window_done)) begin
        hit = 1'b1;
        break;
      end
      if (inject && !injected && col_valid) begin
        kernel_r = KB_R;
        kernel_g = KB_G;
        kernel_b = KB_B;
        start = 1'b1;
        injected = 1'b1;
      end
      rdy = pix_ready;
      v = (i < 16) && (!stall || ($urandom_range(0, 1) == 1));
      pix_valid = v;
      pix_r = 8'(i);
      pix_g = 8'(i + 64);
      pix_b = 8'(i + 128);
      @(posedge clk);
      if (v && rdy) begin
        i++;
        n_acc++;
      end
    end
    pix_valid = 1'b0;
    start = 1'b0;
    chk("run_completed", {71'd0, hit}, 72'd1);
  endtask

  task automatic compare_frame(input string name);
    chk({name, "_len"}, 72'(obs.size()), 72'd16);
    for (int i = 0; i < 16; i++) begin
      if (i < obs.size()) begin
        chk({name, "_kind"}, {71'd0, obs[i].pulse}, {71'd0, exp_tab[i].pulse});
        if (!exp_tab[i].pulse) begin
          chk({name, "_col_r"}, {48'd0, obs[i].r}, {48'd0, exp_tab[i].r});
          chk({name, "_col_g"}, {48'd0, obs[i].g}, {48'd0, exp_tab[i].r + 24'h404040});
          chk({name, "_col_b"}, {48'd0, obs[i].b}, {48'd0, exp_tab[i].r + 24'h808080});
        end
      end
    end
    chk({name, "_cols"}, 72'(n_colv), 72'd12);
    chk({name, "_pulses"}, 72'(n_pulse), 72'd4);
    chk({name, "_frames"}, 72'(n_fdone), 72'd1);
    chk({name, "_first_col_after"}, 72'(first_col_acc), 72'd12);
    chk({name, "_busy_end"}, {71'd0, busy}, 72'd0);
  endtask

  int bad;

  initial begin
    // Expected column stream: {bottom, middle, top} r-values, pulses between windows.
    exp_tab[0]  = '{1'b0, 24'h080400};
    exp_tab[1]  = '{1'b0, 24'h090501};
    exp_tab[2]  = '{1'b0, 24'h0A0602};
    exp_tab[3]  = '{1'b1, 24'h000000};
    exp_tab[4]  = '{1'b0, 24'h090501};
    exp_tab[5]  = '{1'b0, 24'h0A0602};
    exp_tab[6]  = '{1'b0, 24'h0B0703};
    exp_tab[7]  = '{1'b1, 24'h000000};
    exp_tab[8]  = '{1'b0, 24'h0C0804};
    exp_tab[9]  = '{1'b0, 24'h0D0905};
    exp_tab[10] = '{1'b0, 24'h0E0A06};
    exp_tab[11] = '{1'b1, 24'h000000};
    exp_tab[12] = '{1'b0, 24'h0D0905};
    exp_tab[13] = '{1'b0, 24'h0E0A06};
    exp_tab[14] = '{1'b0, 24'h0F0B07};
    exp_tab[15] = '{1'b1, 24'h000000};

    rst_n = 1'b0;
    start = 1'b0;
    kernel_r = '0;
    kernel_g = '0;
    kernel_b = '0;
    pix_valid = 1'b0;
    pix_r = '0;
    pix_g = '0;
    pix_b = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", {71'd0, busy}, 72'd0);
    chk("reset_ready", {71'd0, pix_ready}, 72'd0);
    chk("reset_load_weight", {71'd0, load_weight}, 72'd0);
    chk("reset_weights_r", weights_r, 72'd0);
    rst_n = 1'b1;

    // Start timing and kernel capture.
    clear_obs();
    do_start(KA_R, KA_G, KA_B);
    chk("lw_not_yet", {71'd0, load_weight}, 72'd0);
    @(negedge clk);
    chk("lw_pulse", {71'd0, load_weight}, 72'd1);
    chk("lw_weights_r", weights_r, KA_R);
    chk("lw_weights_g", weights_g, KA_G);
    chk("lw_weights_b", weights_b, KA_B);
    chk("lw_busy", {71'd0, busy}, 72'd1);
    chk("lw_ready_low", {71'd0, pix_ready}, 72'd0);
    @(negedge clk);
    chk("lw_single_cycle", {71'd0, load_weight}, 72'd0);
    chk("fill_ready", {71'd0, pix_ready}, 72'd1);

    // Back-to-back frame.
    run_pixels(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    compare_frame("frame_b2b");

    // Randomly stalled input.
    clear_obs();
    do_start(KB_R, KB_G, KB_B);
    run_pixels(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    compare_frame("frame_stall");
    chk("stall_weights_r", weights_r, KB_R);

    // Start during SWEEP is ignored.
    clear_obs();
    do_start(KA_R, KA_G, KA_B);
    run_pixels(1'b0, 1'b0, 1'b1);
    @(negedge clk);
    compare_frame("frame_busy_start");
    chk("busy_start_weights_r", weights_r, KA_R);
    chk("busy_start_weights_g", weights_g, KA_G);

    // Reset asserted during WDONE.
    clear_obs();
    do_start(KB_R, KB_G, KB_B);
    run_pixels(1'b0, 1'b1, 1'b0);
    chk("pre_reset_wdone", {71'd0, total_window_done}, 72'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_busy", {71'd0, busy}, 72'd0);
    chk("rst_window_done", {71'd0, total_window_done}, 72'd0);
    chk("rst_col_valid", {71'd0, col_valid}, 72'd0);
    chk("rst_frame_done", {71'd0, frame_done}, 72'd0);
    chk("rst_ready", {71'd0, pix_ready}, 72'd0);
    chk("rst_load_weight", {71'd0, load_weight}, 72'd0);
    chk("rst_weights_r", weights_r, 72'd0);
    chk("rst_weights_b", weights_b, 72'd0);
    chk("rst_cols", {input_col_r, input_col_g, input_col_b}, 72'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    pix_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (pix_ready || col_valid || busy) bad++;
    end
    pix_valid = 1'b0;
    chk("no_activity_without_start", 72'(bad), 72'd0);

    clear_obs();
    do_start(KA_R, KA_G, KA_B);
    run_pixels(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    compare_frame("frame_after_reset");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rgb_column_feeder.md
RGB_COLUMN_FEEDER -- requirements
Module: rgb_column_feeder

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, giving the width of each pixel and weight element.
REQ-002 The block SHALL have parameter IMG_W, default 8, giving the frame width in pixels (legal range 3 or more).
REQ-003 The block SHALL have parameter IMG_H, default 8, giving the frame height in pixels (legal range 3 or more).
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset: clk  in  1  rising-edge clock; rst_n  in  1  asynchronous active-low reset.
REQ-005 The block SHALL have start  in  1  single-cycle frame start request.
REQ-006 The block SHALL have kernel_r, kernel_g, kernel_b  in  9*DATA_WIDTH each  3x3 kernels, captured at start.
REQ-007 The block SHALL have pix_valid  in  1, pix_r, pix_g, pix_b  in  DATA_WIDTH each, and pix_ready  out  1, forming the raster-order pixel input handshake.
REQ-008 The block SHALL have load_weight  out  1  single-cycle kernel load strobe to the array.
REQ-009 The block SHALL have weights_r, weights_g, weights_b  out  9*DATA_WIDTH each  captured kernels.
REQ-010 The block SHALL have input_col_r, input_col_g, input_col_b  out  3*DATA_WIDTH each  3-row column; bits [DW-1:0] carry the top (oldest) row and bits [3DW-1:2DW] carry the bottom row.
REQ-011 The block SHALL have col_valid  out  1  marking a column valid.
REQ-012 The block SHALL have total_window_done  out  1  single-cycle end-of-window pulse.
REQ-013 The block SHALL have frame_done  out  1  single-cycle end-of-frame pulse, and busy  out  1, which is high whenever the block is not in IDLE.

Function
REQ-014 The FSM SHALL have the states IDLE, LOAD_W, FILL, SWEEP, WDONE and FINISH.
REQ-015 In IDLE, start=1 SHALL capture kernel_r/g/b into the weights_* registers, clear the row and column counters, and move to LOAD_W; start outside IDLE SHALL be ignored.
REQ-016 LOAD_W SHALL last exactly one cycle with load_weight=1 and then move to FILL.
REQ-017 In FILL, pix_ready SHALL be 1, and each pix_valid&&pix_ready cycle SHALL write the pixel into line buffer slot (row mod 3) at the current column, then advance column and row in raster order.
REQ-018 In FILL, pixels SHALL be accepted without stalls, at one per cycle while pix_valid is held.
REQ-019 When a row completes with rows received >= 3, the FSM SHALL enter SWEEP with x0=0 and k=0; otherwise it SHALL remain in FILL.
REQ-020 pix_ready SHALL be 0 in every state other than FILL, and pix_valid SHALL be ignored there.
REQ-021 In SWEEP, col_valid SHALL be 1 and input_col_* SHALL carry column x0+k from the three most recent rows, ordered oldest row first.
REQ-022 k SHALL increment each SWEEP cycle; after k=2 the FSM SHALL go to WDONE.
REQ-023 WDONE SHALL last one cycle with total_window_done=1 and col_valid=0; each window therefore takes exactly 4 cycles (3 column cycles plus 1 done cycle).
REQ-024 From WDONE, if x0 < IMG_W-3 the FSM SHALL increment x0 and return to SWEEP.
REQ-025 From WDONE, if x0 = IMG_W-3 and rows received < IMG_H, the FSM SHALL return to FILL to accept the next row; the oldest slot is overwritten, giving a vertical stride of 1.
REQ-026 From WDONE, if x0 = IMG_W-3 and rows received = IMG_H, the FSM SHALL go to FINISH.
REQ-027 FINISH SHALL last one cycle with frame_done=1 and then return to IDLE.
REQ-028 Each frame SHALL produce (IMG_W-2)*(IMG_H-2) windows and 3*(IMG_W-2)*(IMG_H-2) col_valid cycles.
REQ-029 All outputs SHALL be registered or decoded directly from registered state, with no combinational path from any input to any output.
REQ-030 input_col_* SHALL be 0 whenever col_valid=0.
REQ-031 The block SHALL pass data through without modification, with no arithmetic on pixels or weights.

Reset
REQ-032 rst_n=0 SHALL asynchronously force the IDLE state; clear all counters; and drive load_weight, col_valid, total_window_done, frame_done, busy, pix_ready, weights_* and input_col_* to 0.
REQ-033 Line buffer contents SHALL NOT require a reset.
REQ-034 Reset mid-frame SHALL abandon the frame; after release, the block SHALL need a new start before it accepts any pixel.

Verification
REQ-035 Directed test, single-cycle start: start with kernel_r=9 distinct bytes -> load_weight=1 for one cycle, 2 cycles after start, with weights_r equal to kernel_r; pix_ready=1 from the next cycle.
REQ-036 Directed test, 4x4 frame, first column: IMG_W=IMG_H=4 with r-pixel=4*y+x streamed back-to-back -> first col_valid after 12 pixels, input_col_r={8'd8,8'd4,8'd0}; pix_ready=0 during the sweep.
REQ-037 Directed test, 4x4 frame totals: the same frame -> per band, columns x=0,1,2 then pulse, then x=1,2,3 then pulse; second band first column={8'd12,8'd8,8'd4}; totals of 12 col_valid, 4 total_window_done and 1 frame_done; then IDLE with busy=0.
REQ-038 Directed test, stalled input: pix_valid toggled randomly -> identical column sequence to REQ-036/REQ-037, with no pixel lost or duplicated.
REQ-039 Directed test, start while busy: start asserted during SWEEP -> ignored; weights_* unchanged.
REQ-040 Directed test, reset mid-frame: rst_n pulsed low during WDONE -> all outputs 0 immediately; no col_valid until a new start plus 12 pixels.
